triangle_rasterizer: RTL and testbench
======================================

# triangle_rasterizer

Sequential successor to the combinational `point_triangulator`. It accepts one triangle over a valid/ready handshake and scans the triangle's screen-clamped bounding box in row-major order. It emits every covered pixel coordinate over a back-pressurable valid/ready stream, then pulses `tri_done`. It sits between triangle setup and the fragment/colour stage of the render pipeline.

## Interface
- `MAX_RESOLUTION_X`, 1280, screen width; `XW = $clog2(MAX_RESOLUTION_X)`
- `MAX_RESOLUTION_Y`, 720, screen height; `YW = $clog2(MAX_RESOLUTION_Y)`
- `clk` in 1: single clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `tri_valid` in 1: triangle vertices present.
- `tri_ready` out 1: high only in IDLE.
- `triangle_P1_x`, `triangle_P2_x`, `triangle_P3_x` in XW each: vertex x.
- `triangle_P1_y`, `triangle_P2_y`, `triangle_P3_y` in YW each: vertex y.
- `pixel_valid` out 1: covered pixel on `pixel_x`/`pixel_y`.
- `pixel_ready` in 1: downstream accepts pixel.
- `pixel_x` out XW: covered pixel x.
- `pixel_y` out YW: covered pixel y.
- `tri_done` out 1: one-cycle pulse when the triangle is fully emitted.

## Operation
- States:
  - IDLE: `tri_ready`=1. On `tri_valid`, latch vertices and go to SETUP.
  - SETUP: 1 cycle. Compute bbox min/max per axis, clamped to [0, MAX-1]. Compute edge start values and per-step deltas. Compute signed doubled area.
    - If area = 0, go to DONE.
    - Otherwise go to SCAN at (xmin, ymin).
  - SCAN: evaluate one bbox position per cycle unless stalled.
    - Order: x ascending within a row, then y ascending.
    - After evaluating (xmax, ymax), go to DRAIN.
  - DRAIN: wait until the output register is empty, then go to DONE.
  - DONE: `tri_done`=1 for 1 cycle, then go to IDLE.
- Edge function for edge a→b: `E(x,y) = (x−xa)(yb−ya) − (y−ya)(xb−xa)`.
  - Operands are signed: differences are XW+1/YW+1 bits; products and accumulators are EDGE_W = XW+YW+4 bits, so no overflow is possible.
  - E is updated incrementally:
    - +dE/dx on x step.
    - Row restart: start value + dE/dy.
  - No multiplier is used in SCAN.
- Covered iff all three E ≥ 0 or all three E ≤ 0.
  - Coverage is winding-independent.
  - Pixels on edges and vertices are included, consistent with the area-sum golden model.
- Degenerate (collinear or coincident) triangles emit no pixels. This is a deliberate difference from the area model.
- Output register: holds one pixel.
  - SCAN advances only when the register is empty or being consumed (`pixel_valid && pixel_ready`).
  - Uncovered positions never stall the scan.
- Clamping affects only the scan range. Edge math always uses the unclamped vertices.
- `tri_valid` is ignored outside IDLE.

## Timing
- Reset values: `tri_ready`=1, `pixel_valid`=0, `pixel_x`=0, `pixel_y`=0, `tri_done`=0, state IDLE.
- Handshake: accept on cycle T. SETUP is T+1. The first bbox position is evaluated at T+2. A covered result appears on `pixel_*` at T+3.
- With no stall, N bbox positions take N cycles. `tri_done` fires at T+N+3 if the last pixel is taken immediately.
- Degenerate triangle: `tri_done` at T+2, no `pixel_valid`.
- Stall: while `pixel_valid && !pixel_ready`, `pixel_x`/`pixel_y` hold stable and the scan freezes. No pixel is dropped or duplicated.
- Reset mid-operation: return to IDLE next cycle, clear `pixel_valid`, suppress `tri_done`. Any partial triangle is discarded.
- Earliest `tri_ready` after `tri_done` is the following cycle (IDLE).

## Structure
- Package `render_pkg`:
  - `XW`, `YW`, `EDGE_W` derived from resolution.
  - State enum {IDLE, SETUP, SCAN, DRAIN, DONE}.
  - Coordinate typedefs.
- Sub-module `edge_stepper`, instantiated 3×:
  - Holds the start value, dE/dx and dE/dy for one edge.
  - Inputs: `load`, `step_x`, `next_row`.
  - Outputs: current E and its sign/zero flags.
- Top level holds the FSM, bbox counters and output register.

## Test plan
- Triangle (0,0),(4,0),(0,4), `pixel_ready`=1 → exactly 15 pixels with x+y ≤ 4, first (0,0), last (0,4), `tri_done` at T+28.
- Same triangle with reversed winding (0,0),(0,4),(4,0) → identical 15-pixel stream.
- Triangle from the first scenario with random `pixel_ready` at 50% duty → same 15-pixel sequence, outputs stable during every stall, exactly one `tri_done`.
- Collinear (1,1),(5,5),(9,9) → no `pixel_valid`, `tri_done` at T+2, `tri_ready` back at T+3.
- Corner triangle (1279,719),(1270,719),(1279,710) → 55 pixels, all with x+y ≥ 1989, none outside 1279×719.
- Reset asserted mid-SCAN on a large triangle, then 200 random non-degenerate triangles → stream matches the area-sum golden model per triangle, no stale pixels after reset.

Source files
------------

// File: rtl/render_pkg.sv
// Shared types, widths and edge-function helpers for the triangle rasterizer.
package render_pkg;

  localparam int unsigned MAX_RESOLUTION_X = 1280;
  localparam int unsigned MAX_RESOLUTION_Y = 720;
  localparam int unsigned XW     = $clog2(MAX_RESOLUTION_X);
  localparam int unsigned YW     = $clog2(MAX_RESOLUTION_Y);
  localparam int unsigned EDGE_W = XW + YW + 4;

  typedef logic [XW-1:0]            coord_x_t;
  typedef logic [YW-1:0]            coord_y_t;
  typedef logic signed [EDGE_W-1:0] edge_t;

  typedef enum logic [2:0] {IDLE, SETUP, SCAN, DRAIN, DONE} state_t;

  typedef struct packed {
    coord_x_t x1;
    coord_x_t x2;
    coord_x_t x3;
    coord_y_t y1;
    coord_y_t y2;
    coord_y_t y3;
  } tri_t;

  // E(px,py) for edge a->b; operands widened so nothing can overflow.
  function automatic edge_t edge_fn(coord_x_t xa, coord_y_t ya, coord_x_t xb, coord_y_t yb,
                                    coord_x_t px, coord_y_t py);
    logic signed [XW:0] ex, bx;
    logic signed [YW:0] ey, by;
    edge_t p0, p1;
    ex = $signed({1'b0, px}) - $signed({1'b0, xa});
    bx = $signed({1'b0, xb}) - $signed({1'b0, xa});
    ey = $signed({1'b0, py}) - $signed({1'b0, ya});
    by = $signed({1'b0, yb}) - $signed({1'b0, ya});
    p0 = EDGE_W'(ex) * EDGE_W'(by);
    p1 = EDGE_W'(ey) * EDGE_W'(bx);
    return p0 - p1;
  endfunction

  function automatic edge_t edge_dx(coord_y_t ya, coord_y_t yb);
    logic signed [YW:0] d;
    d = $signed({1'b0, yb}) - $signed({1'b0, ya});
    return EDGE_W'(d);
  endfunction

  function automatic edge_t edge_dy(coord_x_t xa, coord_x_t xb);
    logic signed [XW:0] d;
    d = $signed({1'b0, xa}) - $signed({1'b0, xb});
    return EDGE_W'(d);
  endfunction

endpackage

// File: rtl/edge_stepper.sv
// Incremental evaluator of one edge function across the row-major bbox scan.
module edge_stepper
  import render_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  logic  step_x,
  input  logic  next_row,
  input  edge_t start_val,
  input  edge_t dedx,
  input  edge_t dedy,
  output logic  e_neg,
  output logic  e_zero
);

  edge_t e_q, e_d, row_q, row_d, dx_q, dx_d, dy_q, dy_d;

  always_comb begin
    e_d   = e_q;
    row_d = row_q;
    dx_d  = dx_q;
    dy_d  = dy_q;
    if (load) begin
      e_d   = start_val;
      row_d = start_val;
      dx_d  = dedx;
      dy_d  = dedy;
    end else if (next_row) begin
      // Row restart is taken from the saved row start, not the running value.
      row_d = row_q + dy_q;
      e_d   = row_q + dy_q;
    end else if (step_x) begin
      e_d = e_q + dx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q   <= '0;
      row_q <= '0;
      dx_q  <= '0;
      dy_q  <= '0;
    end else begin
      e_q   <= e_d;
      row_q <= row_d;
      dx_q  <= dx_d;
      dy_q  <= dy_d;
    end
  end

  assign e_neg  = e_q[EDGE_W-1];
  assign e_zero = (e_q == '0);

endmodule

// File: rtl/triangle_rasterizer.sv
// Scans a triangle's clamped bounding box and streams covered pixels, then pulses tri_done.
module triangle_rasterizer
  import render_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     tri_valid,
  output logic     tri_ready,
  input  coord_x_t triangle_P1_x,
  input  coord_x_t triangle_P2_x,
  input  coord_x_t triangle_P3_x,
  input  coord_y_t triangle_P1_y,
  input  coord_y_t triangle_P2_y,
  input  coord_y_t triangle_P3_y,
  output logic     pixel_valid,
  input  logic     pixel_ready,
  output coord_x_t pixel_x,
  output coord_y_t pixel_y,
  output logic     tri_done
);

  state_t   state_q, state_d;
  tri_t     tri_q, tri_d;
  coord_x_t x_q, x_d, xmin_q, xmin_d, xmax_q, xmax_d;
  coord_y_t y_q, y_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic     pixel_valid_q, pixel_valid_d, tri_ready_q, tri_ready_d, tri_done_q, tri_done_d;
  coord_x_t pixel_x_q, pixel_x_d;
  coord_y_t pixel_y_q, pixel_y_d;

  coord_x_t bx_lo, bx_hi;
  coord_y_t by_lo, by_hi;
  edge_t    start_val [3];
  edge_t    dedx [3];
  edge_t    dedy [3];
  edge_t    area;
  logic     load, step_x, next_row, covered, advance;
  logic [2:0] e_neg, e_zero;

  // Bounding box, edge start values and deltas from the latched (unclamped) vertices.
  always_comb begin
    bx_lo = tri_q.x1;
    bx_hi = tri_q.x1;
    by_lo = tri_q.y1;
    by_hi = tri_q.y1;
    if (tri_q.x2 < bx_lo) bx_lo = tri_q.x2;
    if (tri_q.x3 < bx_lo) bx_lo = tri_q.x3;
    if (tri_q.x2 > bx_hi) bx_hi = tri_q.x2;
    if (tri_q.x3 > bx_hi) bx_hi = tri_q.x3;
    if (tri_q.y2 < by_lo) by_lo = tri_q.y2;
    if (tri_q.y3 < by_lo) by_lo = tri_q.y3;
    if (tri_q.y2 > by_hi) by_hi = tri_q.y2;
    if (tri_q.y3 > by_hi) by_hi = tri_q.y3;
    if (bx_lo > coord_x_t'(MAX_RESOLUTION_X - 1)) bx_lo = coord_x_t'(MAX_RESOLUTION_X - 1);
    if (bx_hi > coord_x_t'(MAX_RESOLUTION_X - 1)) bx_hi = coord_x_t'(MAX_RESOLUTION_X - 1);
    if (by_lo > coord_y_t'(MAX_RESOLUTION_Y - 1)) by_lo = coord_y_t'(MAX_RESOLUTION_Y - 1);
    if (by_hi > coord_y_t'(MAX_RESOLUTION_Y - 1)) by_hi = coord_y_t'(MAX_RESOLUTION_Y - 1);

    start_val[0] = edge_fn(tri_q.x1, tri_q.y1, tri_q.x2, tri_q.y2, bx_lo, by_lo);
    start_val[1] = edge_fn(tri_q.x2, tri_q.y2, tri_q.x3, tri_q.y3, bx_lo, by_lo);
    start_val[2] = edge_fn(tri_q.x3, tri_q.y3, tri_q.x1, tri_q.y1, bx_lo, by_lo);
    dedx[0] = edge_dx(tri_q.y1, tri_q.y2);
    dedx[1] = edge_dx(tri_q.y2, tri_q.y3);
    dedx[2] = edge_dx(tri_q.y3, tri_q.y1);
    dedy[0] = edge_dy(tri_q.x1, tri_q.x2);
    dedy[1] = edge_dy(tri_q.x2, tri_q.x3);
    dedy[2] = edge_dy(tri_q.x3, tri_q.x1);
    area    = edge_fn(tri_q.x1, tri_q.y1, tri_q.x2, tri_q.y2, tri_q.x3, tri_q.y3);
  end

  for (genvar i = 0; i < 3; i++) begin : g_edge
    edge_stepper u_edge (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .step_x    (step_x),
      .next_row  (next_row),
      .start_val (start_val[i]),
      .dedx      (dedx[i]),
      .dedy      (dedy[i]),
      .e_neg     (e_neg[i]),
      .e_zero    (e_zero[i])
    );
  end

  // Inside when no edge disagrees in sign: winding-independent, edges inclusive.
  assign covered = (e_neg == 3'b000) || ((~e_neg & ~e_zero) == 3'b000);
  assign advance = !pixel_valid_q || pixel_ready;

  always_comb begin
    state_d       = state_q;
    tri_d         = tri_q;
    x_d           = x_q;
    y_d           = y_q;
    xmin_d        = xmin_q;
    xmax_d        = xmax_q;
    ymin_d        = ymin_q;
    ymax_d        = ymax_q;
    pixel_valid_d = pixel_valid_q && !pixel_ready;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    load          = 1'b0;
    step_x        = 1'b0;
    next_row      = 1'b0;
    case (state_q)
      IDLE: begin
        if (tri_valid) begin
          tri_d   = '{x1: triangle_P1_x, x2: triangle_P2_x, x3: triangle_P3_x,
                      y1: triangle_P1_y, y2: triangle_P2_y, y3: triangle_P3_y};
          state_d = SETUP;
        end
      end
      SETUP: begin
        load    = 1'b1;
        xmin_d  = bx_lo;
        xmax_d  = bx_hi;
        ymin_d  = by_lo;
        ymax_d  = by_hi;
        x_d     = bx_lo;
        y_d     = by_lo;
        state_d = (area == '0) ? DONE : SCAN;
      end
      SCAN: begin
        if (advance) begin
          pixel_valid_d = covered;
          pixel_x_d     = x_q;
          pixel_y_d     = y_q;
          if (x_q == xmax_q) begin
            if (y_q == ymax_q) begin
              state_d = DRAIN;
            end else begin
              next_row = 1'b1;
              x_d      = xmin_q;
              y_d      = y_q + coord_y_t'(1);
            end
          end else begin
            step_x = 1'b1;
            x_d    = x_q + coord_x_t'(1);
          end
        end
      end
      DRAIN:   if (advance) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    tri_ready_d = (state_d == IDLE);
    tri_done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      tri_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      xmin_q        <= '0;
      xmax_q        <= '0;
      ymin_q        <= '0;
      ymax_q        <= '0;
      pixel_valid_q <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      tri_ready_q   <= 1'b1;
      tri_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      tri_q         <= tri_d;
      x_q           <= x_d;
      y_q           <= y_d;
      xmin_q        <= xmin_d;
      xmax_q        <= xmax_d;
      ymin_q        <= ymin_d;
      ymax_q        <= ymax_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      tri_ready_q   <= tri_ready_d;
      tri_done_q    <= tri_done_d;
    end
  end

  assign tri_ready   = tri_ready_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign tri_done    = tri_done_q;

endmodule

// File: tb/tb_triangle_rasterizer.sv
// Directed table plus reset and random-triangle sequences against an area-sum reference.
module tb_triangle_rasterizer;
  import render_pkg::*;

  logic     clk = 1'b0;
  logic     reset, tri_valid, tri_ready, pixel_valid, pixel_ready, tri_done;
  coord_x_t p1x, p2x, p3x, pixel_x;
  coord_y_t p1y, p2y, p3y, pixel_y;

  always #5 clk = ~clk;

  triangle_rasterizer dut (
    .clk(clk), .reset(reset), .tri_valid(tri_valid), .tri_ready(tri_ready),
    .triangle_P1_x(p1x), .triangle_P2_x(p2x), .triangle_P3_x(p3x),
    .triangle_P1_y(p1y), .triangle_P2_y(p2y), .triangle_P3_y(p3y),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .tri_done(tri_done)
  );

  typedef struct {
    int x1, y1, x2, y2, x3, y3;
    bit rnd_ready;
    int exp_count;
    int exp_done;     // 0: not checked
    bit chk_fl;
    int fx, fy, lx, ly;
    bit corner;
  } vec_t;

  int n_vec = 0;
  int n_fail = 0;
  int exp_x[$];
  int exp_y[$];
  int exp_npos;

  // Results of the most recent run_tri.
  int got_count, done_cyc, first_x, first_y, last_x, last_y, corner_bad;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint area2(longint ax, longint ay, longint bx, longint by,
                                   longint cx, longint cy);
    longint a;
    a = (bx - ax) * (cy - ay) - (cx - ax) * (by - ay);
    return (a < 0) ? -a : a;
  endfunction

  function automatic int min3(int a, int b, int c);
    int m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  function automatic int max3(int a, int b, int c);
    int m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Area-sum golden model over the clamped bbox in row-major order.
  task automatic build_model(input int x1, y1, x2, y2, x3, y3);
    int xl, xh, yl, yh;
    longint a;
    exp_x.delete();
    exp_y.delete();
    xl = min3(x1, x2, x3); xh = max3(x1, x2, x3);
    yl = min3(y1, y2, y3); yh = max3(y1, y2, y3);
    if (xl > 1279) xl = 1279;
    if (xh > 1279) xh = 1279;
    if (yl > 719) yl = 719;
    if (yh > 719) yh = 719;
    exp_npos = (xh - xl + 1) * (yh - yl + 1);
    a = area2(x1, y1, x2, y2, x3, y3);
    if (a == 0) return;
    for (int y = yl; y <= yh; y++)
      for (int x = xl; x <= xh; x++)
        if (area2(x, y, x1, y1, x2, y2) + area2(x, y, x2, y2, x3, y3) +
            area2(x, y, x3, y3, x1, y1) == a) begin
          exp_x.push_back(x);
          exp_y.push_back(y);
        end
  endtask

  task automatic start_tri(input int x1, y1, x2, y2, x3, y3);
    check("tri_ready_idle", tri_ready, 1);
    p1x = coord_x_t'(x1); p2x = coord_x_t'(x2); p3x = coord_x_t'(x3);
    p1y = coord_y_t'(y1); p2y = coord_y_t'(y2); p3y = coord_y_t'(y3);
    tri_valid = 1'b1;
    @(posedge clk);
    #1;
    tri_valid = 1'b0;
  endtask

  task automatic run_tri(input int x1, y1, x2, y2, x3, y3, input bit rnd);
    int cyc, idx;
    bit done, prev_stall;
    int px, py;
    build_model(x1, y1, x2, y2, x3, y3);
    got_count = 0; done_cyc = -1; corner_bad = 0;
    first_x = -1; first_y = -1; last_x = -1; last_y = -1;
    idx = 0; done = 0; prev_stall = 0; px = 0; py = 0;
    start_tri(x1, y1, x2, y2, x3, y3);
    cyc = 1;
    while (!done && cyc < 2000) begin
      if (prev_stall)
        check("stall_hold", {pixel_valid, pixel_x, pixel_y}, {1'b1, coord_x_t'(px), coord_y_t'(py)});
      if (tri_done) begin
        done = 1;
        done_cyc = cyc;
      end else begin
        pixel_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (pixel_valid && pixel_ready) begin
          n_vec++;
          if (idx >= exp_x.size()) begin
            n_fail++;
            $display("FAIL pixel[%0d]: got (%0d,%0d), expected no more pixels", idx, pixel_x, pixel_y);
          end else if (int'(pixel_x) != exp_x[idx] || int'(pixel_y) != exp_y[idx]) begin
            n_fail++;
            $display("FAIL pixel[%0d]: got (%0d,%0d), expected (%0d,%0d)", idx, pixel_x, pixel_y,
                     exp_x[idx], exp_y[idx]);
          end
          if (idx == 0) begin first_x = int'(pixel_x); first_y = int'(pixel_y); end
          last_x = int'(pixel_x); last_y = int'(pixel_y);
          if (int'(pixel_x) + int'(pixel_y) < 1989 || pixel_x > 1279 || pixel_y > 719) corner_bad++;
          idx++;
        end
        prev_stall = pixel_valid && !pixel_ready;
        px = int'(pixel_x); py = int'(pixel_y);
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    if (!done) check("done_timeout", 0, 1);
    got_count = idx;
    check("stream_len", idx, exp_x.size());
    pixel_ready = 1'b1;
    @(posedge clk);
    #1;
    check("done_single_pulse", tri_done, 0);
    check("tri_ready_after_done", tri_ready, 1);
  endtask

  vec_t tbl[5];

  initial begin
    int bad, rx, ry, x1, y1, x2, y2, x3, y3;
    tbl[0] = '{0, 0, 4, 0, 0, 4, 0, 15, 28, 1, 0, 0, 0, 4, 0};
    tbl[1] = '{0, 0, 0, 4, 4, 0, 0, 15, 28, 1, 0, 0, 0, 4, 0};
    tbl[2] = '{0, 0, 4, 0, 0, 4, 1, 15, 0, 1, 0, 0, 0, 4, 0};
    tbl[3] = '{1, 1, 5, 5, 9, 9, 0, 0, 2, 0, 0, 0, 0, 0, 0};
    tbl[4] = '{1279, 719, 1270, 719, 1279, 710, 0, 55, 103, 1, 1279, 710, 1279, 719, 1};

    reset = 1'b1; tri_valid = 1'b0; pixel_ready = 1'b1;
    p1x = '0; p2x = '0; p3x = '0; p1y = '0; p2y = '0; p3y = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tri_ready", tri_ready, 1);
    check("rst_pixel_valid", pixel_valid, 0);
    check("rst_pixel_x", pixel_x, 0);
    check("rst_pixel_y", pixel_y, 0);
    check("rst_tri_done", tri_done, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      run_tri(tbl[i].x1, tbl[i].y1, tbl[i].x2, tbl[i].y2, tbl[i].x3, tbl[i].y3, tbl[i].rnd_ready);
      check($sformatf("count[%0d]", i), got_count, tbl[i].exp_count);
      if (tbl[i].exp_done != 0) check($sformatf("done_cycle[%0d]", i), done_cyc, tbl[i].exp_done);
      if (tbl[i].chk_fl) begin
        check($sformatf("first[%0d]", i), first_x * 1000 + first_y, tbl[i].fx * 1000 + tbl[i].fy);
        check($sformatf("last[%0d]", i), last_x * 1000 + last_y, tbl[i].lx * 1000 + tbl[i].ly);
      end
      if (tbl[i].corner) check("corner_pixels_in_range", corner_bad, 0);
    end

    // Reset in the middle of a large scan must discard everything.
    pixel_ready = 1'b1;
    start_tri(0, 0, 200, 0, 0, 100);
    repeat (50) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_pixel_valid", pixel_valid, 0);
    check("midrst_tri_ready", tri_ready, 1);
    check("midrst_tri_done", tri_done, 0);
    bad = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (pixel_valid || tri_done || !tri_ready) bad++;
    end
    check("post_reset_quiet", bad, 0);

    for (int t = 0; t < 200; t++) begin
      do begin
        rx = $urandom_range(0, 1275);
        ry = $urandom_range(0, 712);
        x1 = rx + $urandom_range(0, 11); y1 = ry + $urandom_range(0, 11);
        x2 = rx + $urandom_range(0, 11); y2 = ry + $urandom_range(0, 11);
        x3 = rx + $urandom_range(0, 11); y3 = ry + $urandom_range(0, 11);
      end while (area2(x1, y1, x2, y2, x3, y3) == 0);
      run_tri(x1, y1, x2, y2, x3, y3, (t % 3) == 0);
      if ((t % 3) != 0) check($sformatf("rand_done[%0d]", t), done_cyc, exp_npos + 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
